// File: rtl/dmem_loader.sv
// Boot-time data-memory table loader sitting between the CPU and data memory.
// Optional read-back verify pass is compiled in with DMEM_LOADER_VERIFY_EN.
module dmem_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        loadControl,
  input  logic [10:0] cpuAdrx,
  input  logic [15:0] cpuDataIn,
  input  logic        cpuWrite,
  input  logic [15:0] memDataOut,
  output logic [10:0] memAdrx,
  output logic [15:0] memDataIn,
  output logic        memWrite,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
`ifdef DMEM_LOADER_VERIFY_EN
    VERIFY = 2'd2,
`endif
    DONE   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic        variant_q, variant_d;

  function automatic logic [15:0] table_word(input logic v, input logic [2:0] p);
    case (p)
      3'd0:    return v ? 16'h0008 : 16'h0007;
      3'd1:    return v ? 16'h0003 : 16'h0005;
      3'd2:    return 16'h0003;
      3'd3:    return 16'h0005;
      3'd4:    return 16'h5A5A;
      3'd5:    return 16'h6767;
      3'd6:    return 16'h003C;
      default: return 16'h00FF;
    endcase
  endfunction

`ifdef DMEM_LOADER_VERIFY_EN
  logic error_q, error_d;
`else
  logic unused_mem_rdata;
  assign unused_mem_rdata = ^memDataOut;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      variant_q <= 1'b0;
`ifdef DMEM_LOADER_VERIFY_EN
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      variant_q <= variant_d;
`ifdef DMEM_LOADER_VERIFY_EN
      error_q   <= error_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    variant_d = variant_q;
`ifdef DMEM_LOADER_VERIFY_EN
    error_d   = error_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = WRITE;
          ptr_d     = '0;
          variant_d = loadControl;
`ifdef DMEM_LOADER_VERIFY_EN
          error_d   = 1'b0;
`endif
        end
      end
      WRITE: begin
        ptr_d = ptr_q + 3'd1;
        if (ptr_q == 3'd7) begin
`ifdef DMEM_LOADER_VERIFY_EN
          state_d = VERIFY;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef DMEM_LOADER_VERIFY_EN
      VERIFY: begin
        ptr_d = ptr_q + 3'd1;
        if (memDataOut != table_word(variant_q, ptr_q)) error_d = 1'b1;
        if (ptr_q == 3'd7) state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Loader-side outputs decode only registered state, so they settle right
  // after the rising edge; idle/done is a pure combinational CPU bypass.
  always_comb begin
    memAdrx   = cpuAdrx;
    memDataIn = cpuDataIn;
    memWrite  = cpuWrite;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      WRITE: begin
        memAdrx   = {8'b0, ptr_q};
        memDataIn = table_word(variant_q, ptr_q);
        memWrite  = 1'b1;
        busy      = 1'b1;
      end
`ifdef DMEM_LOADER_VERIFY_EN
      VERIFY: begin
        memAdrx   = {8'b0, ptr_q};
        memDataIn = table_word(variant_q, ptr_q);
        memWrite  = 1'b0;
        busy      = 1'b1;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef DMEM_LOADER_VERIFY_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_loader.sv
// Directed bench for dmem_loader with a falling-edge-write memory model.
// Works with and without DMEM_LOADER_VERIFY_EN defined.
module tb_dmem_loader;

`ifdef DMEM_LOADER_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        loadControl;
  logic [10:0] cpuAdrx;
  logic [15:0] cpuDataIn;
  logic        cpuWrite;
  logic [15:0] memDataOut;
  logic [10:0] memAdrx;
  logic [15:0] memDataIn;
  logic        memWrite;
  logic        busy;
  logic        done;
  logic        error;

  logic [15:0] mem [0:2047];
  logic        corrupt;
  int unsigned n_cmp;
  int unsigned n_fail;

  logic [15:0] exp_tbl [0:1][0:7];

  typedef struct {
    logic [10:0] adr;
    logic [15:0] din;
    logic        wr;
    logic [10:0] exp_adr;
    logic [15:0] exp_din;
    logic        exp_wr;
  } pt_vec_t;
  pt_vec_t pt_vec [0:3];

  dmem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .loadControl(loadControl),
    .cpuAdrx    (cpuAdrx),
    .cpuDataIn  (cpuDataIn),
    .cpuWrite   (cpuWrite),
    .memDataOut (memDataOut),
    .memAdrx    (memAdrx),
    .memDataIn  (memDataIn),
    .memWrite   (memWrite),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: captures on falling edge, optional corruption of address 5.
  always @(negedge clk) begin
    if (memWrite) mem[memAdrx] <= (corrupt && memAdrx == 11'd5) ? 16'h0000 : memDataIn;
  end
  assign memDataOut = mem[memAdrx];

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [15:0] d);
    cpuAdrx = a; cpuDataIn = d; cpuWrite = 1'b1;
    tick();
    cpuWrite = 1'b0;
  endtask

  task automatic do_load(input logic lc, input logic toggle, input logic restart, input logic cpu_hold);
    start = 1'b1; loadControl = lc;
    tick();
    start = 1'b0;
    if (cpu_hold) begin cpuAdrx = 11'h010; cpuDataIn = 16'h1234; end
    for (int i = 0; i < 8; i++) begin
      if (cpu_hold) cpuWrite = (VERIFY_EN || i != 7);
      if (restart && !VERIFY_EN) start = (i == 4);
      chk("wr_busy", busy, 1'b1);
      chk("wr_done", done, 1'b0);
      chk("wr_memWrite", memWrite, 1'b1);
      chk("wr_memAdrx", memAdrx, i);
      chk("wr_memDataIn", memDataIn, exp_tbl[lc][i]);
      if (i == 0) chk("wr_error_cleared", error, 1'b0);
      if (toggle) loadControl = ~loadControl;
      tick();
    end
    if (VERIFY_EN) begin
      for (int i = 0; i < 8; i++) begin
        if (cpu_hold) cpuWrite = (i != 7);
        if (restart) start = (i == 2);
        chk("vf_busy", busy, 1'b1);
        chk("vf_done", done, 1'b0);
        chk("vf_memWrite", memWrite, 1'b0);
        chk("vf_memAdrx", memAdrx, i);
        tick();
      end
    end
    start = 1'b0;
    chk("end_done", done, 1'b1);
    chk("end_busy", busy, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; corrupt = 1'b0;
    exp_tbl[0][0] = 16'h0007; exp_tbl[0][1] = 16'h0005; exp_tbl[0][2] = 16'h0003; exp_tbl[0][3] = 16'h0005;
    exp_tbl[0][4] = 16'h5A5A; exp_tbl[0][5] = 16'h6767; exp_tbl[0][6] = 16'h003C; exp_tbl[0][7] = 16'h00FF;
    exp_tbl[1][0] = 16'h0008; exp_tbl[1][1] = 16'h0003; exp_tbl[1][2] = 16'h0003; exp_tbl[1][3] = 16'h0005;
    exp_tbl[1][4] = 16'h5A5A; exp_tbl[1][5] = 16'h6767; exp_tbl[1][6] = 16'h003C; exp_tbl[1][7] = 16'h00FF;
    pt_vec[0] = '{11'h123, 16'hABCD, 1'b0, 11'h123, 16'hABCD, 1'b0};
    pt_vec[1] = '{11'h7FF, 16'hFFFF, 1'b1, 11'h7FF, 16'hFFFF, 1'b1};
    pt_vec[2] = '{11'h400, 16'h0001, 1'b1, 11'h400, 16'h0001, 1'b1};
    pt_vec[3] = '{11'h000, 16'h0000, 1'b0, 11'h000, 16'h0000, 1'b0};

    reset = 1'b0; start = 1'b0; loadControl = 1'b1;
    cpuAdrx = 11'h055; cpuDataIn = 16'h0F0F; cpuWrite = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_memAdrx", memAdrx, 11'h055);
    #10 reset = 1'b1;
    tick();
    tick();
    chk("idle_after_rst_busy", busy, 1'b0);
    chk("idle_after_rst_done", done, 1'b0);

    for (int i = 0; i < 4; i++) begin
      cpuAdrx = pt_vec[i].adr; cpuDataIn = pt_vec[i].din; cpuWrite = pt_vec[i].wr;
      #1;
      chk("pt_memAdrx", memAdrx, pt_vec[i].exp_adr);
      chk("pt_memDataIn", memDataIn, pt_vec[i].exp_din);
      chk("pt_memWrite", memWrite, pt_vec[i].exp_wr);
      tick();
    end
    cpuWrite = 1'b0;

    cpu_write(11'h010, 16'hBEEF);

    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) chk("mem_v0", mem[i], exp_tbl[0][i]);
    chk("v0_error", error, 1'b0);

    do_load(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) chk("mem_v1", mem[i], exp_tbl[1][i]);
    chk("stall_mem010", mem[16], 16'hBEEF);
    chk("v1_error", error, 1'b0);

    cpuAdrx = 11'h010; cpuDataIn = 16'h1234; cpuWrite = 1'b1;
    #1;
    chk("done_pt_memWrite", memWrite, 1'b1);
    chk("done_pt_memAdrx", memAdrx, 11'h010);
    chk("done_pt_memDataIn", memDataIn, 16'h1234);
    tick();
    cpuWrite = 1'b0;
    chk("done_mem010", mem[16], 16'h1234);

    corrupt = 1'b1;
    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    corrupt = 1'b0;
    chk("corrupt_mem5", mem[5], 16'h0000);
    chk("corrupt_error", error, VERIFY_EN);
    tick();
    chk("error_sticky", error, VERIFY_EN);
    do_load(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reload_error", error, 1'b0);
    chk("reload_mem5", mem[5], 16'h6767);

    for (int i = 0; i < 8; i++) cpu_write(i[10:0], 16'hDEAD);
    cpuAdrx = 11'h020; cpuDataIn = 16'h0000;
    start = 1'b1; loadControl = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_abort_memAdrx", memAdrx, 11'd3);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_memWrite", memWrite, 1'b0);
    chk("abort_memAdrx", memAdrx, 11'h020);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_abort_busy", busy, 1'b0);
      chk("post_abort_done", done, 1'b0);
    end
    for (int i = 0; i < 3; i++) chk("abort_mem_lo", mem[i], exp_tbl[0][i]);
    for (int i = 3; i < 8; i++) chk("abort_mem_hi", mem[i], 16'hDEAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
